fetch_stage: RTL

- Instruction-fetch stage directly upstream of the decode controller.
- Holds the PC and issues requests to instruction memory, which may take several cycles to answer.
- Registers the returned word into the IF/ID pipeline register. Its low 7 bits drive the controller's Opcode input.
- Supports pipeline stall, branch redirect/flush and a one-entry skid buffer, so no fetched word is lost while decode is stalled.

---
 rtl/fetch_stage.sv | 95 +++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem request, IF/ID register and a
// one-entry skid buffer covering a response that lands during a stall.
module fetch_stage #(
  parameter int unsigned PC_W     = 9,
  parameter int unsigned INST_W   = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [PC_W-1:0]   branch_target,
  output logic [PC_W-1:0]   imem_addr,
  output logic              imem_req,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              imem_ready,
  output logic [PC_W-1:0]   if_pc,
  output logic [INST_W-1:0] if_instr,
  output logic              if_valid,
  output logic [6:0]        if_opcode
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  localparam logic [INST_W-1:0] NOP = INST_W'(32'h0000_0013);

  logic [1:0]        r_state;
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   r_if_pc;
  logic [INST_W-1:0] r_if_instr;
  logic              r_if_valid;
  logic [INST_W-1:0] r_skid;

  logic [PC_W-1:0]   w_pc_inc;
  logic [PC_W-1:0]   w_target;

  assign w_pc_inc = r_pc + PC_W'(4);
  assign w_target = {branch_target[PC_W-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_if_pc    <= '0;
      r_if_instr <= NOP;
      r_if_valid <= 1'b0;
      r_skid     <= NOP;
    end else if (flush) begin
      // redirect wins; any response this cycle belongs to the old path
      r_state    <= S_FETCH;
      r_pc       <= w_target;
      r_if_instr <= NOP;
      r_if_valid <= 1'b0;
      r_skid     <= NOP;
    end else begin
      unique case (r_state)
        S_IDLE: r_state <= S_FETCH;
        S_FETCH: begin
          if (imem_ready && !stall) begin
            r_if_pc    <= r_pc;
            r_if_instr <= imem_rdata;
            r_if_valid <= 1'b1;
            r_pc       <= w_pc_inc;
          end else if (imem_ready) begin
            r_skid  <= imem_rdata;
            r_state <= S_HOLD;
          end else if (!stall) begin
            r_if_instr <= NOP;
            r_if_valid <= 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            r_if_pc    <= r_pc;
            r_if_instr <= r_skid;
            r_if_valid <= 1'b1;
            r_pc       <= w_pc_inc;
            r_state    <= S_FETCH;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign imem_req  = (r_state == S_FETCH);
  assign imem_addr = r_pc;
  assign if_pc     = r_if_pc;
  assign if_instr  = r_if_instr;
  assign if_valid  = r_if_valid;
  assign if_opcode = r_if_instr[6:0];

endmodule
